// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Drives the select lines of a downstream CHANNELS:1 mux through every
//   channel in turn. It samples the single-bit mux output once per channel,
//   after SETTLE wait cycles, and presents the assembled word on a
//   valid/ready handshake. Every output is registered.
//
//   Parameters:
//     CHANNELS : number of mux inputs scanned (2..2**SEL_W)
//     SEL_W    : width of the select bus
//     SETTLE   : extra wait cycles after each select change (0..15)
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     start      in   scan request (honoured in IDLE, or in HOLD with data_ready)
//     mux_out    in   output of the downstream mux
//     sel        out  select bus driven to the mux
//     busy       out  high whenever a scan is running or a word is being held
//     data_out   out  assembled word; bit k was sampled while sel==k
//     data_valid out  data_out holds a complete scan
//     data_ready in   consumer accepts data_out
//     parity     out  even parity of data_out (only with MUX_SCAN_PARITY_EN)
//
//   Optional feature macro: MUX_SCAN_PARITY_EN adds the parity output.
module mux_scan_ctrl #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mux_out,
  output logic [SEL_W-1:0]    sel,
  output logic                busy,
  output logic [CHANNELS-1:0] data_out,
  output logic                data_valid,
  input  logic                data_ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                parity
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
  localparam logic [3:0]       CNT_LOAD = 4'(SETTLE);

  state_t              state, state_n;
  logic [SEL_W-1:0]    sel_n;
  logic [3:0]          cnt, cnt_n;
  logic [CHANNELS-1:0] capture, capture_n;
  logic [CHANNELS-1:0] data_out_n;
  logic                data_valid_n;
  logic                busy_n;

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    cnt_n        = cnt;
    capture_n    = capture;
    data_out_n   = data_out;
    data_valid_n = data_valid;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SETTLE;
          sel_n   = '0;
          cnt_n   = CNT_LOAD;
        end
      end

      S_SETTLE: begin
        if (cnt != '0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          capture_n[sel] = mux_out;
          if (sel != LAST_SEL) begin
            sel_n = sel + SEL_W'(1);
            cnt_n = CNT_LOAD;
          end else begin
            // The last bit goes straight into data_out on the same edge as
            // its capture, so the word does not need an extra pipeline cycle.
            data_out_n   = capture_n;
            data_valid_n = 1'b1;
            state_n      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (data_ready) begin
          data_valid_n = 1'b0;
          sel_n        = '0;
          if (start) begin
            state_n = S_SETTLE;
            cnt_n   = CNT_LOAD;
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        sel_n   = '0;
      end
    endcase

    // busy is registered from the next state so that it lines up with state.
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel        <= '0;
      cnt        <= '0;
      capture    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      cnt        <= cnt_n;
      capture    <= capture_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      busy       <= busy_n;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else begin
      parity <= ^data_out_n;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl. Two instances share one clock and one reset:
// instance a uses SETTLE=1 and instance b uses SETTLE=0. Each instance drives
// a behavioural 8:1 mux. The expected select trace, latency and word are
// computed from the scan rules with plain arithmetic.
module tb_mux_scan_ctrl;

  localparam int C = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, ready_a, muxo_a, busy_a, valid_a;
  logic [2:0] sel_a;
  logic [7:0] ia, dout_a;
  logic       start_b, ready_b, muxo_b, busy_b, valid_b;
  logic [2:0] sel_b;
  logic [7:0] ib, dout_b;
`ifdef MUX_SCAN_PARITY_EN
  logic       par_a, par_b;
`endif

  assign muxo_a = ia[sel_a];
  assign muxo_b = ib[sel_b];

  mux_scan_ctrl #(.CHANNELS(8), .SEL_W(3), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mux_out(muxo_a), .sel(sel_a),
    .busy(busy_a), .data_out(dout_a), .data_valid(valid_a), .data_ready(ready_a)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(par_a)
`endif
  );

  mux_scan_ctrl #(.CHANNELS(8), .SEL_W(3), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mux_out(muxo_b), .sel(sel_b),
    .busy(busy_b), .data_out(dout_b), .data_valid(valid_b), .data_ready(ready_b)
`ifdef MUX_SCAN_PARITY_EN
    , .parity(par_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] sel_tr   [0:255];
  logic       busy_tr  [0:255];
  logic       valid_tr [0:255];

  function automatic int exp_lat(int s);
    return C * (s + 1);
  endfunction

  function automatic logic [2:0] exp_sel(int k, int s);
    return 3'(k / (s + 1));
  endfunction

  function automatic logic [2:0] g_sel(bit b);   return b ? sel_b : sel_a;   endfunction
  function automatic logic       g_busy(bit b);  return b ? busy_b : busy_a; endfunction
  function automatic logic       g_valid(bit b); return b ? valid_b : valid_a; endfunction
  function automatic logic [7:0] g_dout(bit b);  return b ? dout_b : dout_a; endfunction
`ifdef MUX_SCAN_PARITY_EN
  function automatic logic       g_par(bit b);   return b ? par_b : par_a;   endfunction
`endif

  task automatic set_start(bit b, logic v);
    if (b) start_b = v; else start_a = v;
  endtask

  task automatic set_ready(bit b, logic v);
    if (b) ready_b = v; else ready_a = v;
  endtask

  task automatic set_pat(bit b, logic [7:0] p);
    if (b) ib = p; else ia = p;
  endtask

  // Pulses start (optionally with data_ready, for back-to-back from HOLD),
  // then records sel/busy/valid each cycle until data_valid rises or the
  // cycle budget runs out. lat counts cycles after the accepting edge.
  task automatic run_scan(input bit b, input bit rdy, output int lat);
    set_start(b, 1'b1);
    set_ready(b, rdy);
    @(posedge clk); #1;
    set_start(b, 1'b0);
    set_ready(b, 1'b0);
    lat = 0;
    while (g_valid(b) !== 1'b1 && lat < 200) begin
      sel_tr[lat]   = g_sel(b);
      busy_tr[lat]  = g_busy(b);
      valid_tr[lat] = g_valid(b);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(bit b);
    set_ready(b, 1'b1);
    @(posedge clk); #1;
    set_ready(b, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    start_a = 0; ready_a = 0; ia = '0;
    start_b = 0; ready_b = 0; ib = '0;
    #12;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel_a !== 3'd0 || busy_a !== 1'b0 || valid_a !== 1'b0 || dout_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_a: sel=%0d busy=%b valid=%b dout=%h, want 0/0/0/00", sel_a, busy_a, valid_a, dout_a);
    end
    checks++;
    if (sel_b !== 3'd0 || busy_b !== 1'b0 || valid_b !== 1'b0 || dout_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: sel=%0d busy=%b valid=%b dout=%h, want 0/0/0/00", sel_b, busy_b, valid_b, dout_b);
    end
`ifdef MUX_SCAN_PARITY_EN
    checks++;
    if (par_a !== 1'b0 || par_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity: a=%b b=%b, want 0", par_a, par_b);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    ia = 8'hA5;
    run_scan(0, 0, lat);
    checks++;
    if (lat !== exp_lat(1)) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want %0d", lat, exp_lat(1));
    end
    for (int k = 0; k < lat && k < 256; k++) begin
      checks++;
      if (sel_tr[k] !== exp_sel(k, 1) || busy_tr[k] !== 1'b1 || valid_tr[k] !== 1'b0) begin
        errors++;
        $display("FAIL basic_trace[%0d]: sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0",
                 k, sel_tr[k], busy_tr[k], valid_tr[k], exp_sel(k, 1));
      end
    end
    checks++;
    if (dout_a !== 8'hA5 || valid_a !== 1'b1 || busy_a !== 1'b1 || sel_a !== 3'd7) begin
      errors++;
      $display("FAIL basic_word: dout=%h valid=%b busy=%b sel=%0d, want A5/1/1/7", dout_a, valid_a, busy_a, sel_a);
    end
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 5; c++) begin
      start_a = (c == 2);
      @(posedge clk); #1;
      checks++;
      if (dout_a !== 8'hA5 || valid_a !== 1'b1 || busy_a !== 1'b1 || sel_a !== 3'd7) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: dout=%h valid=%b busy=%b sel=%0d, want A5/1/1/7",
                 c, dout_a, valid_a, busy_a, sel_a);
      end
    end
    start_a = 1'b0;
    handshake(0);
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || sel_a !== 3'd0 || dout_a !== 8'hA5) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b busy=%b sel=%0d dout=%h, want 0/0/0/A5",
               valid_a, busy_a, sel_a, dout_a);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    ia = 8'hA5;
    run_scan(0, 0, lat);
    checks++;
    if (lat !== exp_lat(1) || dout_a !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d dout=%h, want %0d/A5", lat, dout_a, exp_lat(1));
    end
    ia = 8'h3C;
    run_scan(0, 1, lat);
    for (int k = 0; k < lat && k < 256; k++) begin
      checks++;
      if (sel_tr[k] !== exp_sel(k, 1) || busy_tr[k] !== 1'b1 || valid_tr[k] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_trace[%0d]: sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0",
                 k, sel_tr[k], busy_tr[k], valid_tr[k], exp_sel(k, 1));
      end
    end
    checks++;
    if (lat !== exp_lat(1) || dout_a !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d dout=%h, want %0d/3C", lat, dout_a, exp_lat(1));
    end
    handshake(0);
  endtask

  task automatic test_reset_midscan;
    int n;
    int lat;
    ia = 8'h5A;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (sel_a !== 3'd4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sel_a !== 3'd4) begin
      errors++;
      $display("FAIL midscan_reach_sel4: sel=%0d, want 4", sel_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel_a !== 3'd0 || busy_a !== 1'b0 || valid_a !== 1'b0 || dout_a !== 8'h00) begin
      errors++;
      $display("FAIL midscan_clear: sel=%0d busy=%b valid=%b dout=%h, want 0/0/0/00", sel_a, busy_a, valid_a, dout_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ia = 8'hFF;
    run_scan(0, 0, lat);
    checks++;
    if (lat !== exp_lat(1) || dout_a !== 8'hFF) begin
      errors++;
      $display("FAIL midscan_rescan: lat=%0d dout=%h, want %0d/FF", lat, dout_a, exp_lat(1));
    end
    handshake(0);
  endtask

  task automatic test_settle0;
    int lat;
    logic [7:0] pats [2];
    pats[0] = 8'h07;
    pats[1] = 8'hA5;
    for (int p = 0; p < 2; p++) begin
      ib = pats[p];
      run_scan(1, 0, lat);
      for (int k = 0; k < lat && k < 256; k++) begin
        checks++;
        if (sel_tr[k] !== exp_sel(k, 0) || busy_tr[k] !== 1'b1 || valid_tr[k] !== 1'b0) begin
          errors++;
          $display("FAIL settle0_trace[%0d]: sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0",
                   k, sel_tr[k], busy_tr[k], valid_tr[k], exp_sel(k, 0));
        end
      end
      checks++;
      if (lat !== exp_lat(0) || dout_b !== pats[p]) begin
        errors++;
        $display("FAIL settle0_word: lat=%0d dout=%h, want %0d/%h", lat, dout_b, exp_lat(0), pats[p]);
      end
`ifdef MUX_SCAN_PARITY_EN
      checks++;
      if (par_b !== ^pats[p]) begin
        errors++;
        $display("FAIL settle0_parity: got %b, want %b", par_b, ^pats[p]);
      end
`endif
      handshake(1);
    end
  endtask

  task automatic test_random;
    int lat;
    int s;
    int hold;
    bit b;
    logic [7:0] pat;
    for (int it = 0; it < 8; it++) begin
      b    = 1'($urandom_range(0, 1));
      s    = b ? 0 : 1;
      pat  = 8'($urandom);
      hold = $urandom_range(0, 3);
      set_pat(b, pat);
      run_scan(b, 0, lat);
      for (int k = 0; k < lat && k < 256; k++) begin
        checks++;
        if (sel_tr[k] !== exp_sel(k, s) || busy_tr[k] !== 1'b1 || valid_tr[k] !== 1'b0) begin
          errors++;
          $display("FAIL random_trace[%0d,%0d]: sel=%0d busy=%b valid=%b, want sel=%0d",
                   it, k, sel_tr[k], busy_tr[k], valid_tr[k], exp_sel(k, s));
        end
      end
      checks++;
      if (lat !== exp_lat(s) || g_dout(b) !== pat) begin
        errors++;
        $display("FAIL random_word[%0d]: lat=%0d dout=%h, want %0d/%h", it, lat, g_dout(b), exp_lat(s), pat);
      end
`ifdef MUX_SCAN_PARITY_EN
      checks++;
      if (g_par(b) !== ^pat) begin
        errors++;
        $display("FAIL random_parity[%0d]: got %b, want %b", it, g_par(b), ^pat);
      end
`endif
      // Scramble the mux inputs while holding: the held word must not move.
      set_pat(b, ~pat);
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        checks++;
        if (g_valid(b) !== 1'b1 || g_dout(b) !== pat) begin
          errors++;
          $display("FAIL random_hold[%0d]: valid=%b dout=%h, want 1/%h", it, g_valid(b), g_dout(b), pat);
        end
      end
      handshake(b);
      checks++;
      if (g_valid(b) !== 1'b0 || g_busy(b) !== 1'b0 || g_sel(b) !== 3'd0 || g_dout(b) !== pat) begin
        errors++;
        $display("FAIL random_release[%0d]: valid=%b busy=%b sel=%0d dout=%h, want 0/0/0/%h",
                 it, g_valid(b), g_busy(b), g_sel(b), g_dout(b), pat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_reset_midscan;
    test_settle0;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
